// File: rtl/shift_sequencer.sv
// shift_sequencer: splits one shift command (0..2^AMT_W-1 positions) into
// steps of at most MAX_STEP positions on a 4-bit arithmetic shifter.
// Latency: ceil(amt/MAX_STEP) SHIFT cycles after acceptance (amt=0 goes
// straight to DONE).
// Backpressure: cmd_ready only in IDLE; the result is held in DONE until
// res_ready.
// Optional macro SHSEQ_STICKY_OVF_EN: res_ovf is the OR of the overflow over
// all steps. When undefined, res_ovf is the overflow of the final step only.

// 4-bit shifter datapath. B = {fill, amount[1:0], dir}.
// X is the shifted word with the fill bit inserted on the vacated side.
// Y is the bits pushed out of the word:
//   - for a left shift they sit in the low end of Y;
//   - for a right shift they sit in the high end of Y.
module arithmetic_shifter (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] x,
   output logic [3:0] y
);
   logic [1:0] amt;
   logic       dir;
   logic       fill;
   logic [7:0] wide;
   logic [3:0] fmask;

   // Shift through an 8-bit window so the pushed-out bits fall into Y.
   always_comb begin
      amt   = b[2:1];
      dir   = b[0];
      fill  = b[3];
      wide  = 8'h00;
      fmask = 4'h0;
      x     = 4'h0;
      y     = 4'h0;
      if (!dir) begin
         wide  = {4'b0000, a} << amt;
         fmask = (4'b0001 << amt) - 4'b0001;
         x     = wide[3:0] | (fill ? fmask : 4'b0000);
         y     = wide[7:4];
      end else begin
         wide  = {a, 4'b0000} >> amt;
         fmask = ~(4'b1111 >> amt);
         x     = wide[7:4] | (fill ? fmask : 4'b0000);
         y     = wide[3:0];
      end
   end
endmodule

module shift_sequencer #(
   parameter int MAX_STEP = 3,
   parameter int AMT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_data,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic             cmd_dir,
   input  logic             cmd_fill,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       res_data,
   output logic [3:0]       res_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [3:0]       work;
   logic [AMT_W-1:0] rem;
   logic             dir_q;
   logic             fill_q;
   logic [1:0]       step;
   logic [3:0]       sh_x;
   logic [3:0]       sh_y;
`ifdef SHSEQ_STICKY_OVF_EN
   logic [3:0]       ovf_acc;
`endif

   // Step size: the remaining amount, capped at MAX_STEP.
   // It is never 0 while in SHIFT.
   always_comb begin
      step = 2'd0;
      if (rem > AMT_W'(MAX_STEP))
         step = 2'(MAX_STEP);
      else
         step = rem[1:0];
   end

   arithmetic_shifter u_shifter (
      .a (work),
      .b ({fill_q, step, dir_q}),
      .x (sh_x),
      .y (sh_y)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         work      <= 4'h0;
         rem       <= '0;
         dir_q     <= 1'b0;
         fill_q    <= 1'b0;
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= 4'h0;
         res_ovf   <= 4'h0;
         busy      <= 1'b0;
`ifdef SHSEQ_STICKY_OVF_EN
         ovf_acc   <= 4'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  work      <= cmd_data;
                  rem       <= cmd_amt;
                  dir_q     <= cmd_dir;
                  fill_q    <= cmd_fill;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef SHSEQ_STICKY_OVF_EN
                  ovf_acc   <= 4'h0;
`endif
                  if (cmd_amt == '0) begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_data  <= cmd_data;
                     res_ovf   <= 4'h0;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work <= sh_x;
               rem  <= rem - AMT_W'(step);
`ifdef SHSEQ_STICKY_OVF_EN
               ovf_acc <= ovf_acc | sh_y;
`endif
               if (rem == AMT_W'(step)) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_data  <= sh_x;
`ifdef SHSEQ_STICKY_OVF_EN
                  res_ovf   <= ovf_acc | sh_y;
`else
                  res_ovf   <= sh_y;
`endif
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
